// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - shares one single-ported SRAM between instruction-fetch and data ports
// Optional SRAM_ARB_STATS_EN adds conflict_cnt/forced_cnt statistics outputs.
module sram_port_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_gnt,
    output logic                i_rvalid,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_req,
    input  logic [DATA_W/8-1:0] d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic [DATA_W/8-1:0] m_w_en,
    output logic [ADDR_W-1:0]   m_address,
    output logic [DATA_W-1:0]   m_write_data,
    input  logic [DATA_W-1:0]   m_read_data
`ifdef SRAM_ARB_STATS_EN
    ,
    output logic [15:0]         conflict_cnt,
    output logic [15:0]         forced_cnt
`endif
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    localparam logic [1:0] RET_NONE = 2'd0;
    localparam logic [1:0] RET_I    = 2'd1;
    localparam logic [1:0] RET_D    = 2'd2;

    logic [CNT_W-1:0] starve_cnt;
    logic [1:0]       ret_state;
    logic [1:0]       ret_next;
    logic             force_i;

    // Data port wins contention unless fetch has been starved long enough.
    always_comb begin
        force_i = (starve_cnt == STARVE_LIM);
        d_gnt   = rst && d_req && !(i_req && force_i);
        i_gnt   = rst && i_req && !d_gnt;
    end

    always_comb begin
        m_w_en       = '0;
        m_address    = '0;
        m_write_data = '0;
        if (d_gnt) begin
            m_w_en       = d_we;
            m_address    = d_addr;
            m_write_data = d_wdata;
        end else if (i_gnt) begin
            m_address    = i_addr;
        end
    end

    always_comb begin
        ret_next = RET_NONE;
        if (i_gnt) begin
            ret_next = RET_I;
        end else if (d_gnt && (d_we == '0)) begin
            ret_next = RET_D;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ret_state  <= RET_NONE;
            starve_cnt <= '0;
        end else begin
            ret_state <= ret_next;
            if (i_req && !i_gnt) begin
                if (starve_cnt != STARVE_LIM) begin
                    starve_cnt <= starve_cnt + 1'b1;
                end
            end else begin
                starve_cnt <= '0;
            end
        end
    end

    // Read data is gated so neither port ever sees the other's words.
    always_comb begin
        i_rvalid = (ret_state == RET_I);
        d_rvalid = (ret_state == RET_D);
        i_rdata  = i_rvalid ? m_read_data : '0;
        d_rdata  = d_rvalid ? m_read_data : '0;
    end

`ifdef SRAM_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            conflict_cnt <= '0;
            forced_cnt   <= '0;
        end else begin
            if (i_req && d_req) begin
                conflict_cnt <= conflict_cnt + 16'd1;
            end
            if (i_gnt && d_req) begin
                forced_cnt <= forced_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - self-checking bench for sram_port_arbiter
// Honours SRAM_ARB_STATS_EN when defined for the whole build.
module tb_sram_port_arbiter;

    localparam int ADDR_W     = 16;
    localparam int DATA_W     = 32;
    localparam int BE_W       = 4;
    localparam int STARVE_MAX = 4;

    localparam logic [1:0] G_NONE = 2'd0;
    localparam logic [1:0] G_I    = 2'd1;
    localparam logic [1:0] G_D    = 2'd2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [DATA_W-1:0] i_rdata;
    logic              d_req;
    logic [BE_W-1:0]   d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic [BE_W-1:0]   m_w_en;
    logic [ADDR_W-1:0] m_address;
    logic [DATA_W-1:0] m_write_data;
    logic [DATA_W-1:0] m_read_data;
`ifdef SRAM_ARB_STATS_EN
    logic [15:0] conflict_cnt;
    logic [15:0] forced_cnt;
    logic [15:0] exp_conflict = 16'd0;
    logic [15:0] exp_forced   = 16'd0;
`endif

    int total = 0;
    int bad   = 0;

    logic [DATA_W-1:0] sram    [0:16383];
    logic [DATA_W-1:0] ref_mem [0:16383];

    int                waited = 0;
    logic [1:0]        exp_g  = G_NONE;
    logic              exp_iv = 1'b0;
    logic              exp_dv = 1'b0;
    logic [DATA_W-1:0] exp_id = '0;
    logic [DATA_W-1:0] exp_dd = '0;

    sram_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_w_en(m_w_en), .m_address(m_address), .m_write_data(m_write_data),
        .m_read_data(m_read_data)
`ifdef SRAM_ARB_STATS_EN
        , .conflict_cnt(conflict_cnt), .forced_cnt(forced_cnt)
`endif
    );

    // Behavioural SRAM: byte-write, one-cycle read latency.
    always @(posedge clk) begin
        for (int b = 0; b < BE_W; b++) begin
            if (m_w_en[b]) sram[m_address[15:2]][8*b +: 8] <= m_write_data[8*b +: 8];
        end
        m_read_data <= sram[m_address[15:2]];
    end

    // Fetch is forced once it has been denied STARVE_MAX cycles in a row.
    function automatic logic [1:0] model_grant(input logic ir, input logic dr, input logic r);
        if (!r) return G_NONE;
        if (dr && !(ir && waited >= STARVE_MAX)) return G_D;
        if (ir) return G_I;
        return G_NONE;
    endfunction

    task automatic drive(input logic ir, input logic [15:0] ia, input logic dr,
                         input logic [3:0] dwe, input logic [15:0] da, input logic [31:0] dwd);
        i_req = ir; i_addr = ia; d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd;
        exp_g = model_grant(ir, dr, rst);
        #1;
    endtask

    task automatic advance();
        exp_iv = (exp_g == G_I);
        exp_dv = (exp_g == G_D) && (d_we == 4'h0);
        exp_id = exp_iv ? ref_mem[i_addr[15:2]] : '0;
        exp_dd = exp_dv ? ref_mem[d_addr[15:2]] : '0;
        if (exp_g == G_D) begin
            for (int b = 0; b < BE_W; b++)
                if (d_we[b]) ref_mem[d_addr[15:2]][8*b +: 8] = d_wdata[8*b +: 8];
        end
        if (!rst || !i_req || exp_g == G_I) waited = 0;
        else if (waited < STARVE_MAX) waited = waited + 1;
`ifdef SRAM_ARB_STATS_EN
        if (!rst) begin
            exp_conflict = 16'd0;
            exp_forced   = 16'd0;
        end else begin
            if (i_req && d_req) exp_conflict = exp_conflict + 16'd1;
            if (exp_g == G_I && d_req) exp_forced = exp_forced + 16'd1;
        end
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(1'b1, 16'h0010, 1'b1, 4'hF, 16'h9000, 32'h12345678);
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) begin
            total++;
            if (i_gnt !== 1'b0 || d_gnt !== 1'b0) begin
                bad++; $display("FAIL reset_gnt: got i=%b d=%b want 0 0", i_gnt, d_gnt);
            end
            total++;
            if (m_w_en !== 4'h0 || m_address !== 16'h0 || m_write_data !== 32'h0) begin
                bad++; $display("FAIL reset_mem: got we=%h a=%h wd=%h want 0", m_w_en, m_address, m_write_data);
            end
            total++;
            if (i_rvalid !== 1'b0 || d_rvalid !== 1'b0 || i_rdata !== 32'h0 || d_rdata !== 32'h0) begin
                bad++; $display("FAIL reset_rvalid: got i=%b d=%b want 0 0", i_rvalid, d_rvalid);
            end
            @(posedge clk); #1;
        end
        waited = 0; exp_iv = 1'b0; exp_dv = 1'b0;
        rst = 1'b1;
        drive(1'b0, 16'h0, 1'b0, 4'h0, 16'h0, 32'h0);
        advance();
    endtask

    task automatic test_fetch_only();
        drive(1'b0, 16'h0, 1'b1, 4'hF, 16'h0010, 32'h00A00093);
        total++;
        if (d_gnt !== 1'b1 || m_w_en !== 4'hF || m_address !== 16'h0010) begin
            bad++; $display("FAIL preload_wr: got gnt=%b we=%h a=%h want 1 f 0010", d_gnt, m_w_en, m_address);
        end
        advance();
        drive(1'b1, 16'h0010, 1'b0, 4'h0, 16'h0, 32'h0);
        total++;
        if (i_gnt !== 1'b1 || d_gnt !== 1'b0 || m_address !== 16'h0010 || m_w_en !== 4'h0) begin
            bad++; $display("FAIL fetch_gnt: got ig=%b dg=%b a=%h we=%h want 1 0 0010 0", i_gnt, d_gnt, m_address, m_w_en);
        end
        advance();
        total++;
        if (i_rvalid !== 1'b1 || i_rdata !== 32'h00A00093 || d_rvalid !== 1'b0) begin
            bad++; $display("FAIL fetch_data: got v=%b d=%h dv=%b want 1 00a00093 0", i_rvalid, i_rdata, d_rvalid);
        end
        drive(1'b0, 16'h0, 1'b0, 4'h0, 16'h0, 32'h0);
        advance();
        total++;
        if (i_rvalid !== 1'b0 || i_rdata !== 32'h0) begin
            bad++; $display("FAIL fetch_stale: got v=%b d=%h want 0 0", i_rvalid, i_rdata);
        end
    endtask

    task automatic test_write_read();
        drive(1'b0, 16'h0, 1'b1, 4'hF, 16'h9000, 32'hDEADBEEF);
        total++;
        if (d_gnt !== 1'b1 || m_write_data !== 32'hDEADBEEF || m_address !== 16'h9000) begin
            bad++; $display("FAIL wr_gnt: got g=%b wd=%h a=%h want 1 deadbeef 9000", d_gnt, m_write_data, m_address);
        end
        advance();
        total++;
        if (d_rvalid !== 1'b0) begin
            bad++; $display("FAIL wr_no_rvalid: got %b want 0", d_rvalid);
        end
        drive(1'b0, 16'h0, 1'b1, 4'h0, 16'h9000, 32'h0);
        advance();
        total++;
        if (d_rvalid !== 1'b1 || d_rdata !== 32'hDEADBEEF || i_rvalid !== 1'b0) begin
            bad++; $display("FAIL raw_read: got v=%b d=%h want 1 deadbeef", d_rvalid, d_rdata);
        end
        drive(1'b0, 16'h0, 1'b0, 4'h0, 16'h0, 32'h0);
        advance();
    endtask

    task automatic test_byte_write();
        drive(1'b0, 16'h0, 1'b1, 4'hF, 16'h9004, 32'h11223344);
        advance();
        drive(1'b0, 16'h0, 1'b1, 4'b0010, 16'h9004, 32'h0000AB00);
        total++;
        if (m_w_en !== 4'b0010) begin
            bad++; $display("FAIL byte_we: got %b want 0010", m_w_en);
        end
        advance();
        drive(1'b0, 16'h0, 1'b1, 4'h0, 16'h9004, 32'h0);
        advance();
        total++;
        if (d_rvalid !== 1'b1 || d_rdata !== 32'h1122AB44) begin
            bad++; $display("FAIL byte_read: got v=%b d=%h want 1 1122ab44", d_rvalid, d_rdata);
        end
        drive(1'b0, 16'h0, 1'b0, 4'h0, 16'h0, 32'h0);
        advance();
    endtask

    task automatic test_contention();
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 16'h0010, 1'b1, 4'h0, 16'h9000, 32'h0);
            total++;
            if (i_gnt !== (k % 5 == 4) || d_gnt !== (k % 5 != 4)) begin
                bad++; $display("FAIL contend_gnt[%0d]: got i=%b d=%b want i=%b", k, i_gnt, d_gnt, (k % 5 == 4));
            end
            advance();
            total++;
            if (k % 5 == 4) begin
                if (i_rvalid !== 1'b1 || i_rdata !== 32'h00A00093 || d_rvalid !== 1'b0) begin
                    bad++; $display("FAIL contend_i_data[%0d]: got v=%b d=%h want 1 00a00093", k, i_rvalid, i_rdata);
                end
            end else begin
                if (d_rvalid !== 1'b1 || d_rdata !== 32'hDEADBEEF || i_rvalid !== 1'b0) begin
                    bad++; $display("FAIL contend_d_data[%0d]: got v=%b d=%h want 1 deadbeef", k, d_rvalid, d_rdata);
                end
            end
        end
`ifdef SRAM_ARB_STATS_EN
        total++;
        if (conflict_cnt !== exp_conflict || forced_cnt !== exp_forced) begin
            bad++; $display("FAIL stats: got c=%0d f=%0d want c=%0d f=%0d", conflict_cnt, forced_cnt, exp_conflict, exp_forced);
        end
`endif
        drive(1'b0, 16'h0, 1'b0, 4'h0, 16'h0, 32'h0);
        advance();
    endtask

    task automatic test_random();
        logic              ip = 1'b0, dp = 1'b0;
        logic [15:0]       ia = '0, da = '0;
        logic [3:0]        dwe = '0;
        logic [31:0]       dwd = '0;
        logic [15:0]       ea;
        logic [3:0]        ewe;
        logic [31:0]       ewd;
        int                cur_wait = 0;
        for (int k = 0; k < 16; k++) begin
            drive(1'b0, 16'h0, 1'b1, 4'hF, 16'hA000 + 16'(4 * k), $urandom);
            advance();
        end
        for (int n = 0; n < 300; n++) begin
            if (!ip) begin
                ip = $urandom_range(0, 1) == 1;
                ia = 16'hA000 + 16'(4 * $urandom_range(0, 15));
            end
            if (!dp) begin
                dp = $urandom_range(0, 3) != 0;
                da = 16'hA000 + 16'(4 * $urandom_range(0, 15));
                case ($urandom_range(0, 3))
                    0, 1:    dwe = 4'h0;
                    2:       dwe = 4'hF;
                    default: dwe = 4'($urandom);
                endcase
                dwd = $urandom;
            end
            drive(ip, ia, dp, dwe, da, dwd);
            ea  = (exp_g == G_D) ? da : (exp_g == G_I) ? ia : 16'h0;
            ewe = (exp_g == G_D) ? dwe : 4'h0;
            ewd = (exp_g == G_D) ? dwd : 32'h0;
            total++;
            if (i_gnt !== (exp_g == G_I) || d_gnt !== (exp_g == G_D)) begin
                bad++; $display("FAIL rnd_gnt[%0d]: got i=%b d=%b want g=%0d", n, i_gnt, d_gnt, exp_g);
            end
            total++;
            if (m_address !== ea || m_w_en !== ewe || m_write_data !== ewd) begin
                bad++; $display("FAIL rnd_mem[%0d]: got a=%h we=%h wd=%h want a=%h we=%h wd=%h",
                                n, m_address, m_w_en, m_write_data, ea, ewe, ewd);
            end
            if (ip && !i_gnt) cur_wait++;
            else cur_wait = 0;
            total++;
            if (cur_wait > STARVE_MAX) begin
                bad++; $display("FAIL rnd_starve[%0d]: got wait=%0d want <=%0d", n, cur_wait, STARVE_MAX);
            end
            advance();
            total++;
            if (i_rvalid !== exp_iv || i_rdata !== exp_id || d_rvalid !== exp_dv || d_rdata !== exp_dd) begin
                bad++; $display("FAIL rnd_ret[%0d]: got iv=%b id=%h dv=%b dd=%h want iv=%b id=%h dv=%b dd=%h",
                                n, i_rvalid, i_rdata, d_rvalid, d_rdata, exp_iv, exp_id, exp_dv, exp_dd);
            end
            if (exp_g == G_I) ip = 1'b0;
            if (exp_g == G_D) dp = 1'b0;
        end
        drive(1'b0, 16'h0, 1'b0, 4'h0, 16'h0, 32'h0);
        advance();
    endtask

    task automatic test_reset_mid_read();
        drive(1'b0, 16'h0, 1'b1, 4'h0, 16'h9000, 32'h0);
        advance();
        total++;
        if (d_rvalid !== 1'b1 || d_rdata !== 32'hDEADBEEF) begin
            bad++; $display("FAIL mid_pre: got v=%b d=%h want 1 deadbeef", d_rvalid, d_rdata);
        end
        rst = 1'b0;
        drive(1'b1, 16'h0010, 1'b1, 4'h0, 16'h9000, 32'h0);
        total++;
        if (i_gnt !== 1'b0 || d_gnt !== 1'b0 || m_address !== 16'h0) begin
            bad++; $display("FAIL mid_gnt: got i=%b d=%b a=%h want 0 0 0", i_gnt, d_gnt, m_address);
        end
        advance();
        total++;
        if (d_rvalid !== 1'b0 || i_rvalid !== 1'b0 || d_rdata !== 32'h0) begin
            bad++; $display("FAIL mid_drop: got dv=%b iv=%b dd=%h want 0 0 0", d_rvalid, i_rvalid, d_rdata);
        end
`ifdef SRAM_ARB_STATS_EN
        total++;
        if (conflict_cnt !== 16'd0 || forced_cnt !== 16'd0) begin
            bad++; $display("FAIL mid_stats: got c=%0d f=%0d want 0 0", conflict_cnt, forced_cnt);
        end
`endif
        rst = 1'b1;
        drive(1'b0, 16'h0, 1'b1, 4'h0, 16'h9000, 32'h0);
        total++;
        if (d_gnt !== 1'b1) begin
            bad++; $display("FAIL mid_regnt: got %b want 1", d_gnt);
        end
        advance();
        total++;
        if (d_rvalid !== 1'b1 || d_rdata !== 32'hDEADBEEF) begin
            bad++; $display("FAIL mid_reissue: got v=%b d=%h want 1 deadbeef", d_rvalid, d_rdata);
        end
        drive(1'b0, 16'h0, 1'b0, 4'h0, 16'h0, 32'h0);
        advance();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_fetch_only();
        test_write_read();
        test_byte_write();
        test_contention();
        test_random();
        test_reset_mid_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
